// File: rtl/suma_pkg.sv
// suma_pkg -- shared definitions for the chunked sequential adder/subtractor.
//   state_t  : FSM states (IDLE, CALC, DONE)
//   OP_SUMA  : op encoding for A+B+Cin
//   OP_RESTA : op encoding for A-B-Cin (Cin acts as borrow-in)
//   chunk_ok : elaboration-time check that WIDTH is a whole number of CHUNKs
package suma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_SUMA  = 1'b0;
    localparam logic OP_RESTA = 1'b1;

    // True when a WIDTH-bit operand splits into an integer number of chunks.
    function automatic bit chunk_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/suma_bloque.sv
// suma_bloque -- CHUNK-bit combinational ripple adder.
//   A, B : CHUNK-bit addends
//   Cin  : carry into bit 0
//   S    : CHUNK-bit sum
//   Cout : carry out of bit CHUNK-1
//   Cmsb : carry into bit CHUNK-1 (used for signed overflow detection)
module suma_bloque #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] A,
    input  logic [CHUNK-1:0] B,
    input  logic             Cin,
    output logic [CHUNK-1:0] S,
    output logic             Cout,
    output logic             Cmsb
);

    logic carry;

    // Ripple the carry bit by bit; the carry seen by the top bit is captured
    // on the way past so the caller can compute overflow.
    always_comb begin
        carry = Cin;
        Cmsb  = 1'b0;
        S     = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                Cmsb = carry;
            end
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/suma_secuencial.sv
// suma_secuencial -- multi-cycle adder/subtractor, CHUNK bits per clock,
// least-significant chunk first, with start/busy/done handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted while busy=0 (IDLE or DONE)
//   op         : OP_SUMA (A+B+Cin) or OP_RESTA (A-B-Cin)
//   A, B, Cin  : operands, sampled on the accepting edge only
//   busy       : high while chunks are being computed
//   done       : one-cycle pulse, results valid from this cycle
//   S          : result (saturated on overflow when SUMA_SAT_EN is defined)
//   ST         : {Cout, raw sum}
//   Cout       : carry out of MSB (for subtraction 1 = no borrow)
//   OV         : two's-complement overflow
// Optional feature macro: SUMA_SAT_EN (signed saturation of S).
module suma_secuencial
    import suma_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH:0]   ST,
    output logic             Cout,
    output logic             OV
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_chunk
        $error("suma_secuencial: WIDTH must be an integer multiple of CHUNK");
    end

    state_t           state, state_next;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_reg, b_reg, work;
    logic             carry;
    logic             accept, last;
    logic [CHUNK-1:0] blk_s;
    logic             blk_cout, blk_cmsb;
    logic [WIDTH-1:0] raw, s_next;
    logic             ov_next;

    // A new request is taken whenever no chunks are in flight.
    assign accept = start && (state != CALC);
    assign last   = (state == CALC) && (k == KLAST);

    // The single ripple block works on whichever chunk k currently selects.
    suma_bloque #(.CHUNK(CHUNK)) u_bloque (
        .A    (a_reg[k*CHUNK +: CHUNK]),
        .B    (b_reg[k*CHUNK +: CHUNK]),
        .Cin  (carry),
        .S    (blk_s),
        .Cout (blk_cout),
        .Cmsb (blk_cmsb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. DONE can chain straight into CALC.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (k == KLAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and per-chunk work. Subtraction is folded into addition
    // by inverting B and the borrow-in at capture time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            work  <= '0;
            carry <= 1'b0;
            k     <= '0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= (op == OP_RESTA) ? ~B : B;
            carry <= (op == OP_RESTA) ? ~Cin : Cin;
            k     <= '0;
        end else if (state == CALC) begin
            work[k*CHUNK +: CHUNK] <= blk_s;
            carry                  <= blk_cout;
            k                      <= last ? '0 : k + 1'b1;
        end
    end

    // Full result as it will look once the final chunk is written.
    always_comb begin
        raw                  = work;
        raw[WIDTH-1 -: CHUNK] = blk_s;
    end

    assign ov_next = blk_cmsb ^ blk_cout;

`ifdef SUMA_SAT_EN
    // Clamp to the signed limit on the side indicated by A's sign.
    always_comb begin
        s_next = raw;
        if (ov_next) begin
            s_next = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign s_next = raw;
`endif

    // Result registers change only on completion, so partial sums never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            ST   <= '0;
            Cout <= 1'b0;
            OV   <= 1'b0;
        end else if (last) begin
            S    <= s_next;
            ST   <= {blk_cout, raw};
            Cout <= blk_cout;
            OV   <= ov_next;
        end
    end

endmodule

// File: tb/tb_suma_secuencial.sv
// tb_suma_secuencial -- directed, table-driven bench for suma_secuencial
// at WIDTH=16, CHUNK=4. Expected values are hand-computed; saturated S
// values are selected with SUMA_SAT_EN to match the build.
module tb_suma_secuencial;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_s;
        logic [16:0] exp_st;
        logic        exp_cout;
        logic        exp_ov;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        busy;
    logic        done;
    logic [15:0] S;
    logic [16:0] ST;
    logic        Cout;
    logic        OV;

    int checks = 0;
    int errors = 0;
    vec_t vecs[8];

    suma_secuencial #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .ST    (ST),
        .Cout  (Cout),
        .OV    (OV)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counted, and reported if it does not match.
    task automatic checkOutput(input string name, input logic [16:0] actual,
                               input logic [16:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive a request at the current time (caller sits on a falling edge).
    task automatic setInputs(input vec_t v);
        op    = v.op;
        A     = v.a;
        B     = v.b;
        Cin   = v.cin;
        start = 1'b1;
    endtask

    // Step falling edges until done, counting busy cycles; start is dropped
    // after the first edge. A bounded budget guards against a stuck FSM.
    task automatic waitDone(output int busyCnt, output bit ok);
        busyCnt = 0;
        ok      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busyCnt++;
        end
    endtask

    task automatic checkResult(input string tag, input vec_t v);
        checkOutput({tag, " S"}, {1'b0, S}, {1'b0, v.exp_s});
        checkOutput({tag, " ST"}, ST, v.exp_st);
        checkOutput({tag, " Cout"}, {16'd0, Cout}, {16'd0, v.exp_cout});
        checkOutput({tag, " OV"}, {16'd0, OV}, {16'd0, v.exp_ov});
    endtask

    // Full single operation: latency, busy length, results, single-cycle done.
    task automatic applyStimulus(input string tag, input vec_t v);
        int cnt;
        bit ok;
        @(negedge clk);
        setInputs(v);
        waitDone(cnt, ok);
        checkOutput({tag, " done seen"}, {16'd0, ok}, 17'd1);
        checkOutput({tag, " busy cycles"}, 17'(cnt), 17'd4);
        checkResult(tag, v);
        @(negedge clk);
        checkOutput({tag, " done pulse width"}, {16'd0, done}, 17'd0);
    endtask

    initial begin
        int cnt;
        bit ok;

        // op, a, b, cin, S, ST, Cout, OV
        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 17'h05555, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 17'h10000, 1'b1, 1'b0};
`ifdef SUMA_SAT_EN
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 17'h08000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h8000, 17'h17FFF, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h8000, 17'h10000, 1'b1, 1'b1};
`else
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 17'h08000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 17'h17FFF, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 17'h10000, 1'b1, 1'b1};
`endif
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 17'h0FFFE, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'h00FF, 16'h0F01, 1'b1, 16'h1001, 17'h01001, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000E, 17'h1000E, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        A     = '0;
        B     = '0;
        Cin   = 1'b0;

        // Reset held for two cycles: everything idle and zero.
        repeat (2) @(negedge clk);
        checkOutput("reset busy", {16'd0, busy}, 17'd0);
        checkOutput("reset done", {16'd0, done}, 17'd0);
        checkOutput("reset S", {1'b0, S}, 17'd0);
        checkOutput("reset ST", ST, 17'd0);
        checkOutput("reset Cout", {16'd0, Cout}, 17'd0);
        checkOutput("reset OV", {16'd0, OV}, 17'd0);
        rst_n = 1'b1;

        $display("[TB] table-driven vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // start while busy, with other operands and changing inputs: ignored.
        $display("[TB] start while busy");
        @(negedge clk);
        setInputs(vecs[0]);
        @(negedge clk);
        checkOutput("ignore busy", {16'd0, busy}, 17'd1);
        op    = 1'b0;
        A     = 16'hFFFF;
        B     = 16'h0001;
        start = 1'b1;
        waitDone(cnt, ok);
        checkOutput("ignore done seen", {16'd0, ok}, 17'd1);
        checkOutput("ignore busy cycles", 17'(cnt), 17'd3);
        checkResult("ignore", vecs[0]);
        @(negedge clk);
        checkOutput("ignore no requeue busy", {16'd0, busy}, 17'd0);
        checkOutput("ignore no requeue done", {16'd0, done}, 17'd0);

        // Back-to-back: new start while done is high.
        $display("[TB] back-to-back");
        @(negedge clk);
        setInputs(vecs[2]);
        waitDone(cnt, ok);
        checkOutput("b2b first done", {16'd0, ok}, 17'd1);
        checkResult("b2b first", vecs[2]);
        setInputs(vecs[3]);
        waitDone(cnt, ok);
        checkOutput("b2b second done", {16'd0, ok}, 17'd1);
        checkOutput("b2b second busy cycles", 17'(cnt), 17'd4);
        checkResult("b2b second", vecs[3]);

        // Reset at chunk 2: immediate idle, outputs cleared, no done later.
        $display("[TB] reset mid-operation");
        @(negedge clk);
        setInputs(vecs[1]);
        repeat (3) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", {16'd0, busy}, 17'd0);
        checkOutput("midreset done", {16'd0, done}, 17'd0);
        checkOutput("midreset S", {1'b0, S}, 17'd0);
        checkOutput("midreset ST", ST, 17'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) ok = 1'b1;
        end
        checkOutput("midreset no activity", {16'd0, ok}, 17'd0);
        checkOutput("midreset S held", {1'b0, S}, 17'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/suma_secuencial.md
# suma_secuencial

Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock, least-significant chunk first, with a start/busy/done handshake. It is the next generation of the team's combinational ripple adders: it is generic in width and chunk size, and adds subtraction, signed-overflow detection and registered results. It is intended for datapaths where a full-width ripple chain would not close timing.

## Interface
- WIDTH, 16: operand width in bits. Must be an integer multiple of CHUNK.
- CHUNK, 4: bits processed per cycle. NCHUNK = WIDTH/CHUNK.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; accepted only while busy=0.
- op  in  1  0 = A+B+Cin; 1 = A−B−Cin (Cin acts as borrow-in).
- A, B  in  WIDTH  operands, sampled on the accepting edge only.
- Cin  in  1  carry/borrow-in, sampled with A and B.
- busy  out  1  high while chunks are being computed.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- S  out  WIDTH  result (see Configuration).
- ST  out  WIDTH+1  {Cout, raw unsaturated sum}.
- Cout  out  1  carry out of the MSB. For subtraction, 1 = no borrow.
- OV  out  1  two's-complement overflow.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - CALC: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE → CALC on start. CALC → DONE after chunk index NCHUNK−1. DONE → CALC on start, otherwise DONE → IDLE.
- Accept: latch A, B' = op ? ~B : B, and carry = op ? ~Cin : Cin. Clear chunk index k to 0.
- CALC, each cycle: compute the CHUNK-bit sum of A[k], B'[k] and carry. Write it into the work register at chunk k, update carry, and set k ← k+1.
- Final chunk: Cout = carry out of bit WIDTH−1. OV = carry into bit WIDTH−1 XOR Cout.
- Output registers S, ST, Cout and OV load only on the CALC→DONE edge. They hold until the next completion and never show partial results.
- start while busy=1 is ignored. No queueing.
- start during DONE is accepted, giving back-to-back operation.
- Reset, including mid-operation: state IDLE; busy, done, S, ST, Cout, OV and k all 0; the in-flight operation is discarded.

## Timing
- start sampled high at edge t: busy=1 from t through t+NCHUNK−1, then done=1 for the single cycle after edge t+NCHUNK.
- Latency from the start edge to done is NCHUNK+1 cycles (5 for 16/4). Peak throughput is one result per NCHUNK+1 cycles.
- Operand changes after the accepting edge have no effect.
- Combinational path per cycle is one CHUNK-bit ripple plus the chunk multiplexers.

## Configuration
- SUMA_SAT_EN defined: when OV=1, S saturates to signed limits.
  - Positive overflow: S = 0 followed by WIDTH−1 ones.
  - Negative overflow: S = 1 followed by WIDTH−1 zeros.
  - The sign is taken from A's MSB.
  - ST, Cout and OV remain raw.
- SUMA_SAT_EN undefined: S always equals ST[WIDTH−1:0]. The saturation logic is absent.

## Structure
- Package suma_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the op encoding constants (OP_SUMA = 0, OP_RESTA = 1);
  - an elaboration check that WIDTH % CHUNK == 0.
- Sub-module suma_bloque: parametrised CHUNK-bit combinational ripple adder with ports A, B, Cin, S, Cout and carry-into-MSB. Exactly one instance sits in the datapath.
- Top level contains the FSM, chunk counter, operand/work registers and output registers.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Reset: rst_n low for 2 cycles → all outputs 0, busy=0.
- Add 0x1234 + 0x4321, Cin=0:
  - busy high exactly 4 cycles;
  - done pulses on the 5th cycle;
  - S=0x5555, ST=0x05555, Cout=0, OV=0.
- Add 0xFFFF + 0x0001, Cin=0 → S=0x0000, Cout=1, OV=0.
- Add 0x7FFF + 0x0001:
  - OV=1, ST=0x08000;
  - S=0x8000 without SUMA_SAT_EN, 0x7FFF with it.
- Subtract 0x0005 − 0x0007, Cin=0 → S=0xFFFE, Cout=0 (borrow), OV=0.
  - Then 0x8000 − 0x0001: OV=1, S=0x7FFF without SUMA_SAT_EN, 0x8000 with it.
- start pulsed while busy with other operands → ignored, first result unchanged.
- start during done → second result 5 cycles later.
- rst_n asserted at chunk 2 → immediate IDLE, no done pulse, S=0.
